// File: rtl/cfu_requant_stage.sv
// cfu_requant_stage
//  Requantizes signed 32-bit dot-product accumulators from the CFU SIMD MAC
//  to int8. The four-stage valid/ready pipeline does the following:
//    S1 bias add
//    S2 saturating rounding-doubling high multiply
//    S3 rounding arithmetic right shift (round half away from zero)
//    S4 output offset, activation clamp, sign-extension
//  All stages shift together whenever the output register is free or drained.
//
//  Optional feature macro: REQUANT_PACK_EN
//    When defined, four successive S4 bytes are packed into one output word,
//    lane 0 in bits [7:0]. When undefined, no packer logic exists.
//
//  Ports
//    clk        rising-edge clock
//    reset      asynchronous active-low reset
//    in_valid   accumulator valid
//    in_ready   stage accepts in_acc this cycle
//    in_acc     signed accumulator
//    cfg_we     config write strobe
//    cfg_addr   0 bias, 1 mult, 2 shift, 3 out_offset, 4 act_min, 5 act_max
//    cfg_wdata  config write data
//    out_valid  out_data valid
//    out_ready  consumer accepts out_data
//    out_data   requantized result
//    idle       no stage holds a valid item
module cfu_requant_stage #(
    parameter int ACC_W   = 32,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [ACC_W-1:0] cfg_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             idle
);

    localparam int PROD_W = 2 * ACC_W;
    localparam int OFF_W  = 9;

    localparam logic [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACT_MIN_RST = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACT_MAX_RST = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    localparam logic signed [PROD_W-1:0] ONE_W     = {{(PROD_W-1){1'b0}}, 1'b1};
    localparam logic signed [PROD_W-1:0] NUDGE_POS = ONE_W << (ACC_W-2);
    localparam logic signed [PROD_W-1:0] NUDGE_NEG = ONE_W - NUDGE_POS;
    // Added to a negative sum before the arithmetic shift so the divide truncates toward zero.
    localparam logic signed [PROD_W-1:0] TRUNC_ADJ = (ONE_W << (ACC_W-1)) - ONE_W;

    logic [ACC_W-1:0]   bias_r, mult_r, offset_r, act_min_r, act_max_r;
    logic [SHIFT_W-1:0] shift_r;

    logic               advance_s;
    logic               s1_v_r, s2_v_r, s3_v_r, out_valid_r;
    logic [ACC_W-1:0]   s1_x_r, s2_h_r, s3_q_r, out_data_r;

    logic [ACC_W-1:0]         x_s, h_s, mask_s, rem_s, thr_s, sh_s, q_s, y_s, lo_s, clip_s;
    logic signed [PROD_W-1:0] prod_s, nudge_s, sum_s, quot_s;
    logic [OUT_W-1:0]         res_byte_s;
    logic                     unused_s;

    // Configuration registers; narrow fields are sign-extended on write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_r    <= {ACC_W{1'b0}};
            mult_r    <= MAX_POS;
            shift_r   <= {SHIFT_W{1'b0}};
            offset_r  <= {ACC_W{1'b0}};
            act_min_r <= ACT_MIN_RST;
            act_max_r <= ACT_MAX_RST;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    bias_r    <= cfg_wdata;
                3'd1:    mult_r    <= cfg_wdata;
                3'd2:    shift_r   <= cfg_wdata[SHIFT_W-1:0];
                3'd3:    offset_r  <= {{(ACC_W-OFF_W){cfg_wdata[OFF_W-1]}}, cfg_wdata[OFF_W-1:0]};
                3'd4:    act_min_r <= {{(ACC_W-OUT_W){cfg_wdata[OUT_W-1]}}, cfg_wdata[OUT_W-1:0]};
                3'd5:    act_max_r <= {{(ACC_W-OUT_W){cfg_wdata[OUT_W-1]}}, cfg_wdata[OUT_W-1:0]};
                default: ;
            endcase
        end
    end

    // S1 bias add and S2 rounding-doubling high multiply.
    always_comb begin
        x_s     = in_acc + bias_r;
        prod_s  = $signed({{ACC_W{s1_x_r[ACC_W-1]}}, s1_x_r}) *
                  $signed({{ACC_W{mult_r[ACC_W-1]}}, mult_r});
        nudge_s = prod_s[PROD_W-1] ? NUDGE_NEG : NUDGE_POS;
        sum_s   = prod_s + nudge_s;
        quot_s  = sum_s[PROD_W-1] ? ((sum_s + TRUNC_ADJ) >>> (ACC_W-1))
                                  : (sum_s >>> (ACC_W-1));
        // The only product that does not fit: (-2^31) * (-2^31).
        if ((s1_x_r == MIN_NEG) && (mult_r == MIN_NEG)) begin
            h_s = MAX_POS;
        end else begin
            h_s = quot_s[ACC_W-1:0];
        end
    end

    // S3 rounding right shift; the threshold is one higher for negatives so
    // exact halves round away from zero. Shift is kept separate from the add
    // so the arithmetic shift stays signed.
    always_comb begin
        mask_s = (ONE << shift_r) - ONE;
        rem_s  = s2_h_r & mask_s;
        thr_s  = (mask_s >> 1) + {{(ACC_W-1){1'b0}}, s2_h_r[ACC_W-1]};
        sh_s   = $signed(s2_h_r) >>> shift_r;
        q_s    = sh_s + ((rem_s > thr_s) ? ONE : {ACC_W{1'b0}});
    end

    // S4 offset and clamp; the max clamp is applied last so it wins when min > max.
    always_comb begin
        y_s = s3_q_r + offset_r;
        if ($signed(y_s) < $signed(act_min_r)) begin
            lo_s = act_min_r;
        end else begin
            lo_s = y_s;
        end
        if ($signed(lo_s) > $signed(act_max_r)) begin
            clip_s = act_max_r;
        end else begin
            clip_s = lo_s;
        end
        res_byte_s = clip_s[OUT_W-1:0];
    end

    assign unused_s = ^{quot_s[PROD_W-1:ACC_W], clip_s[ACC_W-1:OUT_W]};

    // S1..S3 pipeline registers; all shift together on advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
            s3_v_r <= 1'b0;
            s1_x_r <= {ACC_W{1'b0}};
            s2_h_r <= {ACC_W{1'b0}};
            s3_q_r <= {ACC_W{1'b0}};
        end else if (advance_s) begin
            s1_v_r <= in_valid;
            s1_x_r <= x_s;
            s2_v_r <= s1_v_r;
            s2_h_r <= h_s;
            s3_v_r <= s2_v_r;
            s3_q_r <= q_s;
        end
    end

`ifdef REQUANT_PACK_EN
    logic [1:0]         lane_r;
    logic [3*OUT_W-1:0] pack_r;

    // The output register is only occupied by a full packed word, so "packer
    // full and out_valid" reduces to out_valid.
    assign advance_s = ~out_valid_r | out_ready;

    // Packer: lanes 0..2 shift in from the top, lane 3 completes the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_r      <= 2'd0;
            pack_r      <= {(3*OUT_W){1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
        end else if (advance_s) begin
            if (s3_v_r) begin
                if (lane_r == 2'd3) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= {res_byte_s, pack_r};
                end else begin
                    out_valid_r <= 1'b0;
                    pack_r      <= {res_byte_s, pack_r[3*OUT_W-1:OUT_W]};
                end
                lane_r <= lane_r + 2'd1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign idle = ~(s1_v_r | s2_v_r | s3_v_r | out_valid_r | (lane_r != 2'd0));
`else
    assign advance_s = ~out_valid_r | out_ready;

    // Output register: one sign-extended result per word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
        end else if (advance_s) begin
            out_valid_r <= s3_v_r;
            if (s3_v_r) begin
                out_data_r <= {{(ACC_W-OUT_W){res_byte_s[OUT_W-1]}}, res_byte_s};
            end
        end
    end

    assign idle = ~(s1_v_r | s2_v_r | s3_v_r | out_valid_r);
`endif

    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule
